// File: rtl/wb_ram_bank_mux_if.sv
// Wishbone classic slave port plus the banked-SRAM side of wb_ram_bank_mux.
// Signal names keep the _i/_o suffixes as seen from the mux.
interface wb_ram_bank_mux_if #(
  parameter int NUM_BANKS      = 2,
  parameter int RAM_ADDR_WIDTH = 11
);
  logic [31:0]               wb_addr_i;
  logic [31:0]               wb_wdata_i;
  logic [3:0]                wb_sel_i;
  logic                      wb_we_i;
  logic                      wb_stb_i;
  logic                      wb_cyc_i;
  logic [31:0]               wb_rdata_o;
  logic                      wb_ack_o;
  logic                      wb_err_o;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_o;
  logic [31:0]               ram_wdata_o;
  logic [3:0]                ram_be_o;
  logic [NUM_BANKS-1:0]      ram_en_o;
  logic [NUM_BANKS-1:0]      ram_we_o;
  logic [NUM_BANKS*32-1:0]   ram_rdata_i;

  modport slave (
    input  wb_addr_i, wb_wdata_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i, ram_rdata_i,
    output wb_rdata_o, wb_ack_o, wb_err_o,
    output ram_addr_o, ram_wdata_o, ram_be_o, ram_en_o, ram_we_o
  );

  modport master (
    output wb_addr_i, wb_wdata_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i, ram_rdata_i,
    input  wb_rdata_o, wb_ack_o, wb_err_o,
    input  ram_addr_o, ram_wdata_o, ram_be_o, ram_en_o, ram_we_o
  );
endinterface

// File: rtl/wb_ram_bank_mux.sv
// Wishbone classic slave decoding the bus address onto NUM_BANKS synchronous
// RAM banks; every output is registered, unmapped addresses answer with err.
module wb_ram_bank_mux #(
  parameter int                                  NUM_BANKS      = 2,
  parameter int                                  BANK_SEL_LSB   = 13,
  parameter int                                  BANK_SEL_WIDTH = 7,
  parameter logic [NUM_BANKS*BANK_SEL_WIDTH-1:0] BANK_MASKS     = {7'h19, 7'h18},
  parameter int                                  RAM_ADDR_WIDTH = 11,
  parameter int                                  READ_LATENCY   = 1
) (
  input logic              wb_clk_i,
  input logic              rst_ni,
  wb_ram_bank_mux_if.slave bus
);
  localparam int BANK_IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CNT_W      = 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BANK_IDX_W-1:0]     bank_q, bank_d;
  logic                      abort_q, abort_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      ack_q, ack_d;
  logic                      err_q, err_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]               ram_wdata_q, ram_wdata_d;
  logic [3:0]                ram_be_q, ram_be_d;
  logic [NUM_BANKS-1:0]      ram_en_q, ram_en_d;
  logic [NUM_BANKS-1:0]      ram_we_q, ram_we_d;

  logic [BANK_SEL_WIDTH-1:0] sel_field;
  logic                      hit;
  logic [BANK_IDX_W-1:0]     hit_idx;
  logic [31:0]               rd_bank [NUM_BANKS];
  logic                      req;
  logic                      unused_addr;

  assign sel_field   = bus.wb_addr_i[BANK_SEL_LSB +: BANK_SEL_WIDTH];
  assign req         = bus.wb_cyc_i & bus.wb_stb_i;
  assign unused_addr = ^bus.wb_addr_i;

  // Scanning downwards lets the lowest matching bank win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (sel_field == BANK_MASKS[b*BANK_SEL_WIDTH +: BANK_SEL_WIDTH]) begin
        hit     = 1'b1;
        hit_idx = BANK_IDX_W'(b);
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) rd_bank[b] = bus.ram_rdata_i[b*32 +: 32];
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bank_d      = bank_q;
    abort_d     = abort_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_be_d    = ram_be_q;
    ram_en_d    = '0;
    ram_we_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            ram_en_d[hit_idx] = 1'b1;
            ram_we_d[hit_idx] = bus.wb_we_i & (|bus.wb_sel_i);
            ram_addr_d        = bus.wb_addr_i[RAM_ADDR_WIDTH+1:2];
            ram_wdata_d       = bus.wb_wdata_i;
            ram_be_d          = bus.wb_sel_i;
            bank_d            = hit_idx;
            abort_d           = 1'b0;
            if (bus.wb_we_i) begin
              state_d = ACK;
            end else begin
              state_d = WAIT;
              cnt_d   = CNT_INIT;
            end
          end else begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
      end
      WAIT: begin
        // A dropped cyc only suppresses the response; the RAM access runs on.
        if (cnt_q == '0) begin
          if (abort_q || !bus.wb_cyc_i) begin
            state_d = IDLE;
          end else begin
            rdata_d = rd_bank[bank_q];
            ack_d   = 1'b1;
            state_d = ACK;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (!bus.wb_cyc_i) abort_d = 1'b1;
        end
      end
      ACK: begin
        // Writes arrive with ack low and raise it here; reads arrive with it high.
        if (!ack_q && bus.wb_cyc_i) ack_d = 1'b1;
        else                        state_d = IDLE;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, matching real register behaviour.
  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bank_q      <= '0;
      abort_q     <= 1'b0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_be_q    <= '0;
      ram_en_q    <= '0;
      ram_we_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bank_q      <= bank_d;
      abort_q     <= abort_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_be_q    <= ram_be_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
    end
  end

  assign bus.wb_rdata_o  = rdata_q;
  assign bus.wb_ack_o    = ack_q;
  assign bus.wb_err_o    = err_q;
  assign bus.ram_addr_o  = ram_addr_q;
  assign bus.ram_wdata_o = ram_wdata_q;
  assign bus.ram_be_o    = ram_be_q;
  assign bus.ram_en_o    = ram_en_q;
  assign bus.ram_we_o    = ram_we_q;
endmodule

// File: tb/tb_wb_ram_bank_mux.sv
// Directed bench: three mux instances (READ_LATENCY 1, 2, 3) share one bus
// stimulus, each with its own behavioural RAM whose data turns valid late.
module tb_wb_ram_bank_mux;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic        we, stb, cyc;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int RL = g + 1;
    wb_ram_bank_mux_if #(.NUM_BANKS(2), .RAM_ADDR_WIDTH(11)) bus ();
    // NOTE: the model memory is deliberately not reset; every word read is written first.
    logic [31:0] mem [2][2048];
    logic [3:0]  age = 4'd0;
    int          en_pulses = 0;
    logic        rd_valid;
    wire  [84:0] all_out = {bus.wb_ack_o, bus.wb_err_o, bus.wb_rdata_o, bus.ram_addr_o,
                            bus.ram_wdata_o, bus.ram_be_o, bus.ram_en_o, bus.ram_we_o};

    assign bus.wb_addr_i  = addr;
    assign bus.wb_wdata_i = wdata;
    assign bus.wb_sel_i   = sel;
    assign bus.wb_we_i    = we;
    assign bus.wb_stb_i   = stb;
    assign bus.wb_cyc_i   = cyc;

    wb_ram_bank_mux #(.READ_LATENCY(RL)) dut (.wb_clk_i(clk), .rst_ni(rst_n), .bus(bus));

    // Read data is valid from the RL-th cycle of ram_en onwards, garbage before.
    assign rd_valid = (|bus.ram_en_o) ? (RL == 1) : (age != 4'd0 && int'(age) >= RL - 1);

    always_comb begin
      bus.ram_rdata_i = '0;
      for (int b = 0; b < 2; b++)
        bus.ram_rdata_i[32*b +: 32] = rd_valid ? mem[b][bus.ram_addr_o] : 32'hBAD0_BAD0;
    end

    always @(posedge clk) begin
      if (|bus.ram_en_o) begin
        age       <= 4'd1;
        en_pulses <= en_pulses + 1;
      end else if (age != 4'd0 && age != 4'hF) begin
        age <= age + 4'd1;
      end
      for (int b = 0; b < 2; b++)
        if (bus.ram_en_o[b] && bus.ram_we_o[b])
          for (int i = 0; i < 4; i++)
            if (bus.ram_be_o[i]) mem[b][bus.ram_addr_o][8*i +: 8] <= bus.ram_wdata_o[8*i +: 8];
    end
  end

  wire        d0_ack   = g_dut[0].bus.wb_ack_o;
  wire        d0_err   = g_dut[0].bus.wb_err_o;
  wire [31:0] d0_rdata = g_dut[0].bus.wb_rdata_o;
  wire [1:0]  d0_en    = g_dut[0].bus.ram_en_o;
  wire [1:0]  d0_we    = g_dut[0].bus.ram_we_o;
  wire [10:0] d0_addr  = g_dut[0].bus.ram_addr_o;
  wire [3:0]  d0_be    = g_dut[0].bus.ram_be_o;
  wire [31:0] d0_wdata = g_dut[0].bus.ram_wdata_o;
  wire        d1_ack   = g_dut[1].bus.wb_ack_o;
  wire [31:0] d1_rdata = g_dut[1].bus.wb_rdata_o;
  wire [1:0]  d1_en    = g_dut[1].bus.ram_en_o;
  wire [1:0]  d1_we    = g_dut[1].bus.ram_we_o;
  wire        d2_ack   = g_dut[2].bus.wb_ack_o;
  wire [31:0] d2_rdata = g_dut[2].bus.wb_rdata_o;
  wire [1:0]  d2_en    = g_dut[2].bus.ram_en_o;
  wire [254:0] all_dut_out = {g_dut[0].all_out, g_dut[1].all_out, g_dut[2].all_out};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic w);
    addr = a; wdata = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
  endtask

  task automatic release_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic settle();
    release_bus();
    repeat (6) step();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    drive(a, d, s, 1'b1);
    step();
    step();
    release_bus();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    addr = '0; wdata = '0; sel = '0;
    release_bus();
    repeat (3) step();
    checks++;
    if (all_dut_out !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h, expected 0", all_dut_out);
    end
    #3 rst_n = 1'b1;
    step();
    checks++;
    if (all_dut_out !== '0) begin
      errors++; $display("FAIL reset_release_idle: got %h, expected 0", all_dut_out);
    end
  endtask

  task automatic test_write_read();
    drive(32'h0003_0010, 32'hDEAD_BEEF, 4'hF, 1'b1);
    step();
    checks++;
    if ({d0_en, d0_we, d0_addr, d0_be, d0_wdata, d0_ack} !==
        {2'b01, 2'b01, 11'h004, 4'hF, 32'hDEAD_BEEF, 1'b0}) begin
      errors++; $display("FAIL wr_cycle1 en/we/addr/be/wdata/ack: got %b %b %h %h %h %b, expected 01 01 004 f deadbeef 0",
                         d0_en, d0_we, d0_addr, d0_be, d0_wdata, d0_ack);
    end
    step();
    checks++;
    if ({d0_ack, d0_err, d0_en} !== 4'b1000) begin
      errors++; $display("FAIL wr_ack_cycle2 ack/err/en: got %b %b %b, expected 1 0 00", d0_ack, d0_err, d0_en);
    end
    release_bus();
    step();
    checks++;
    if ({d0_ack, d0_en} !== 3'b000) begin
      errors++; $display("FAIL wr_ack_single ack/en: got %b %b, expected 0 00", d0_ack, d0_en);
    end
    drive(32'h0003_0010, 32'h0, 4'hF, 1'b0);
    step();
    checks++;
    if ({d0_en, d0_we, d0_ack} !== 5'b01000) begin
      errors++; $display("FAIL rd_cycle1 en/we/ack: got %b %b %b, expected 01 00 0", d0_en, d0_we, d0_ack);
    end
    step();
    checks++;
    if ({d0_ack, d0_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL rd_ack_rl1 ack/rdata: got %b %h, expected 1 deadbeef", d0_ack, d0_rdata);
    end
    settle();
  endtask

  task automatic test_byte_write();
    do_write(32'h0003_2008, 32'h1122_3344, 4'hF);
    drive(32'h0003_2008, 32'h0000_AB00, 4'b0010, 1'b1);
    step();
    checks++;
    if ({d0_en, d0_we, d0_be, d0_addr} !== {2'b10, 2'b10, 4'b0010, 11'h002}) begin
      errors++; $display("FAIL bw_cycle1 en/we/be/addr: got %b %b %b %h, expected 10 10 0010 002",
                         d0_en, d0_we, d0_be, d0_addr);
    end
    step();
    checks++;
    if (d0_ack !== 1'b1) begin
      errors++; $display("FAIL bw_ack_cycle2: got %b, expected 1", d0_ack);
    end
    release_bus();
    step();
    drive(32'h0003_2008, 32'h0, 4'hF, 1'b0);
    step();
    step();
    checks++;
    if ({d0_ack, d0_rdata} !== {1'b1, 32'h1122_AB44}) begin
      errors++; $display("FAIL bw_readback ack/rdata: got %b %h, expected 1 1122ab44", d0_ack, d0_rdata);
    end
    settle();
    drive(32'h0003_0010, 32'hFFFF_FFFF, 4'h0, 1'b1);
    step();
    checks++;
    if ({d0_en, d0_we} !== 4'b0100) begin
      errors++; $display("FAIL sel0_cycle1 en/we: got %b %b, expected 01 00", d0_en, d0_we);
    end
    step();
    checks++;
    if (d0_ack !== 1'b1) begin
      errors++; $display("FAIL sel0_ack: got %b, expected 1", d0_ack);
    end
    settle();
  endtask

  task automatic test_latency3();
    int         p0;
    logic [4:0] ack_hist;
    logic [31:0] rd4;
    do_write(32'h0003_2010, 32'h1234_5678, 4'hF);
    p0 = g_dut[2].en_pulses;
    ack_hist = '0;
    rd4 = '0;
    drive(32'h0003_2010, 32'h0, 4'hF, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step();
      ack_hist[i-1] = d2_ack;
      if (i == 4) begin
        rd4 = d2_rdata;
        release_bus();
      end
    end
    checks++;
    if (ack_hist !== 5'b01000) begin
      errors++; $display("FAIL rl3_ack_cycles (bit0=cycle1): got %b, expected 01000", ack_hist);
    end
    checks++;
    if (rd4 !== 32'h1234_5678) begin
      errors++; $display("FAIL rl3_rdata_cycle4: got %h, expected 12345678", rd4);
    end
    checks++;
    if (g_dut[2].en_pulses - p0 !== 1) begin
      errors++; $display("FAIL rl3_en_pulses: got %0d, expected 1", g_dut[2].en_pulses - p0);
    end
    settle();
  endtask

  task automatic test_unmapped();
    drive(32'h0004_0000, 32'h0, 4'hF, 1'b0);
    step();
    checks++;
    if ({d0_err, d0_ack, d0_en, d0_we} !== 6'b100000) begin
      errors++; $display("FAIL unmapped_cycle1 err/ack/en/we: got %b %b %b %b, expected 1 0 00 00",
                         d0_err, d0_ack, d0_en, d0_we);
    end
    drive(32'h0003_0014, 32'hCAFE_F00D, 4'hF, 1'b1);
    step();
    checks++;
    if ({d0_err, d0_ack, d0_en} !== 4'b0000) begin
      errors++; $display("FAIL unmapped_cycle2 err/ack/en: got %b %b %b, expected 0 0 00", d0_err, d0_ack, d0_en);
    end
    step();
    checks++;
    if ({d0_en, d0_we, d0_ack} !== 5'b01010) begin
      errors++; $display("FAIL after_err_accept en/we/ack: got %b %b %b, expected 01 01 0", d0_en, d0_we, d0_ack);
    end
    step();
    checks++;
    if ({d0_ack, d0_err} !== 2'b10) begin
      errors++; $display("FAIL after_err_ack ack/err: got %b %b, expected 1 0", d0_ack, d0_err);
    end
    settle();
  endtask

  task automatic test_stb_low();
    logic [3:0] seen;
    addr = 32'h0003_0010; wdata = 32'h7777_7777; sel = 4'hF; we = 1'b1;
    cyc = 1'b1; stb = 1'b0;
    seen = '0;
    repeat (3) begin
      step();
      seen = seen | {d0_en, d0_ack, d0_err};
    end
    checks++;
    if (seen !== 4'b0000) begin
      errors++; $display("FAIL stb_low_no_action en/ack/err: got %b, expected 0000", seen);
    end
    settle();
  endtask

  task automatic test_abort();
    logic acc;
    drive(32'h0003_0010, 32'h0, 4'hF, 1'b0);
    repeat (3) step();
    checks++;
    if ({d1_ack, d1_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL rl2_read ack/rdata: got %b %h, expected 1 deadbeef", d1_ack, d1_rdata);
    end
    settle();
    drive(32'h0003_2008, 32'h0, 4'hF, 1'b0);
    step();
    step();
    acc = d1_ack;
    release_bus();
    step();
    acc = acc | d1_ack;
    checks++;
    if ({acc, d1_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL abort_no_ack ack/rdata: got %b %h, expected 0 deadbeef", acc, d1_rdata);
    end
    drive(32'h0003_0018, 32'h55AA_55AA, 4'hF, 1'b1);
    step();
    checks++;
    if ({d1_en, d1_we} !== 4'b0101) begin
      errors++; $display("FAIL abort_next_accept en/we: got %b %b, expected 01 01", d1_en, d1_we);
    end
    step();
    checks++;
    if ({d1_ack, d1_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL abort_next_ack ack/rdata: got %b %h, expected 1 deadbeef", d1_ack, d1_rdata);
    end
    settle();
  endtask

  task automatic test_reset_mid();
    drive(32'h0003_0010, 32'h0, 4'hF, 1'b0);
    step();
    checks++;
    if ({d0_en, d2_en} !== 4'b0101) begin
      errors++; $display("FAIL rst_mid_pre en0/en2: got %b %b, expected 01 01", d0_en, d2_en);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (all_dut_out !== '0) begin
      errors++; $display("FAIL rst_mid_async_clear: got %h, expected 0", all_dut_out);
    end
    #3 rst_n = 1'b1;
    release_bus();
    step();
    checks++;
    if (all_dut_out !== '0) begin
      errors++; $display("FAIL rst_mid_no_pending: got %h, expected 0", all_dut_out);
    end
    drive(32'h0003_0010, 32'h0BAD_F00D, 4'hF, 1'b1);
    step();
    checks++;
    if ({d0_ack, d0_en, d0_we} !== 5'b00101) begin
      errors++; $display("FAIL rst_mid_wr_cycle1 ack/en/we: got %b %b %b, expected 0 01 01", d0_ack, d0_en, d0_we);
    end
    step();
    checks++;
    if ({d0_ack, d0_err} !== 2'b10) begin
      errors++; $display("FAIL rst_mid_wr_ack ack/err: got %b %b, expected 1 0", d0_ack, d0_err);
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_write();
    test_latency3();
    test_unmapped();
    test_stb_low();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_ram_bank_mux.md
Name: wb_ram_bank_mux

Overview:
Single-clock Wishbone classic slave that decodes a bus address onto NUM_BANKS synchronous RAM banks. Each bank can be IRAM, DRAM or scratch. Supports byte-lane writes, a configurable RAM read latency, and an error response for unmapped addresses. Sits between the core's data/instruction Wishbone bus and the on-chip SRAM macros.

Parameters:
NUM_BANKS, 2, number of RAM banks (1..8).
BANK_SEL_LSB, 13, lowest wb_addr_i bit of the bank-select field.
BANK_SEL_WIDTH, 7, width of the bank-select field.
BANK_MASKS, {7'h19, 7'h18}, packed NUM_BANKS*BANK_SEL_WIDTH match values; slice b belongs to bank b (bank 0 = 7'h18).
RAM_ADDR_WIDTH, 11, RAM word-address width.
READ_LATENCY, 1, cycles from the RAM enable edge to valid ram_rdata_i (1..4).

Ports:
wb_clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
wb_addr_i  in  32  byte address
wb_wdata_i  in  32  write data
wb_sel_i  in  4  byte selects
wb_we_i  in  1  1 = write, 0 = read
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_rdata_o  out  32  read data
wb_ack_o  out  1  acknowledge
wb_err_o  out  1  error (unmapped address)
ram_addr_o  out  RAM_ADDR_WIDTH  word address, taken from wb_addr_i[RAM_ADDR_WIDTH+1:2]
ram_wdata_o  out  32  write data
ram_be_o  out  4  byte enables
ram_en_o  out  NUM_BANKS  per-bank access enable
ram_we_o  out  NUM_BANKS  per-bank write enable
ram_rdata_i  in  NUM_BANKS*32  per-bank read data; slice b belongs to bank b

Behaviour:
- One clock (wb_clk_i). Reset is asynchronous, active-low (rst_ni).
- All outputs are registered. Reset values: every output is 0; state = IDLE; latency counter = 0.
- Decode: bank b hits when wb_addr_i[BANK_SEL_LSB +: BANK_SEL_WIDTH] equals BANK_MASKS slice b. If several banks hit, the lowest index wins. No hit means unmapped.
- FSM states: IDLE, WAIT, ACK, ERR.
- IDLE:
  - On cyc & stb with a hit, at the next edge: ram_en_o[b]=1; ram_we_o[b]=wb_we_i & |wb_sel_i; latch ram_addr_o, ram_wdata_o and ram_be_o (= wb_sel_i); latch the bank index.
  - Writes go to ACK. Reads go to WAIT with counter = READ_LATENCY-1.
  - On cyc & stb with no hit: go to ERR. No RAM enable is raised.
- ram_en_o and ram_we_o are high for exactly one cycle per accepted request.
- WAIT: decrement the counter each cycle. When it reaches 0, at that edge: capture the latched bank's ram_rdata_i slice into wb_rdata_o, set wb_ack_o=1, go to ACK.
- ACK: wb_ack_o is high for exactly this one cycle, then cleared; return to IDLE.
- ERR: wb_err_o is high for exactly one cycle; return to IDLE.
- Request sampled at edge 0 gives these response cycles:
  - Write: ack in cycle 2.
  - Read: ack in cycle 1+READ_LATENCY, with wb_rdata_o valid in the same cycle.
  - Error: err in cycle 1.
- wb_rdata_o holds its last read value. Writes and errors do not change it.
- Back-to-back: IDLE accepts a new request in the cycle after ACK or ERR. There are no dead cycles beyond that.
- Write with wb_sel_i=0: ram_en_o pulses, ram_we_o stays 0, still acked.
- Abort: if cyc is low in any cycle of WAIT, or in the cycle ACK would assert:
  - no ack is issued and wb_rdata_o is not updated;
  - the RAM access already issued is not cancelled;
  - the FSM returns to IDLE after the counter expires.
- stb low with cyc high in IDLE: no action.
- Reset mid-operation: all outputs clear immediately (asynchronous). No pending ack or err survives reset.
- wb_ack_o and wb_err_o are never high together.

Test Plan:
- Write 0xDEADBEEF, sel=4'hF, address 0x0003_0010 (bank 0), then read the same address with READ_LATENCY=1 -> ram_en_o=2'b01 and ram_we_o=2'b01 in cycle 1, ram_addr_o=11'h004, write ack in cycle 2; read ack in cycle 2 with wb_rdata_o=0xDEADBEEF.
- Byte write sel=4'b0010, data 0x0000AB00, address 0x0003_2008 (bank 1) -> ram_we_o=2'b10, ram_be_o=4'b0010, ram_addr_o=11'h002, ack in cycle 2.
- READ_LATENCY=3 read from bank 1, model returns 0x12345678 in cycle 4 -> single ack in cycle 4 with wb_rdata_o=0x12345678; exactly one ram_en_o pulse.
- Unmapped address 0x0004_0000 -> wb_err_o high only in cycle 1; ram_en_o, ram_we_o and wb_ack_o stay 0; next request is accepted in cycle 2.
- Abort: READ_LATENCY=2 read, cyc dropped in cycle 2 -> no ack, wb_rdata_o unchanged, FSM back in IDLE and a new request accepted in cycle 3.
- Reset asserted in cycle 1 of a read -> all outputs 0 immediately; after release, a fresh write completes normally with ack in cycle 2.
